// File: rtl/instruction_fetch_pkg.sv
// Shared CPU package: fetch state encoding, the condition-instruction
// opcode and the condition-code encoding used by fetch and the decoder.
package instruction_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } fetch_state_e;

    localparam logic [1:0] COND_OPCODE = 2'b11;

    typedef enum logic [2:0] {
        CC_NEVER  = 3'b000,
        CC_EQZ    = 3'b001,
        CC_LTZ    = 3'b010,
        CC_LEZ    = 3'b011,
        CC_ALWAYS = 3'b100,
        CC_NEZ    = 3'b101,
        CC_GEZ    = 3'b110,
        CC_GTZ    = 3'b111
    } cond_code_e;

    // True when the instruction byte carries the condition opcode in its top bits
    function automatic logic is_cond_inst(input logic [7:0] instByte);
        return instByte[7:6] == COND_OPCODE;
    endfunction

endpackage

// File: rtl/instruction_fetch_condition_unit.sv
// condition_unit: evaluates a signed 8-bit value against a 3-bit condition code.
module condition_unit
    import instruction_fetch_pkg::*;
(
    input  logic [2:0] code,
    input  logic [7:0] value,
    output logic       taken
);

    logic w_zero;
    logic w_neg;

    assign w_zero = (value == 8'h00);
    assign w_neg  = value[7];

    // Decode the condition code against the sign/zero flags of the value
    always_comb begin
        taken = 1'b0;
        case (cond_code_e'(code))
            CC_NEVER:  taken = 1'b0;
            CC_EQZ:    taken = w_zero;
            CC_LTZ:    taken = w_neg;
            CC_LEZ:    taken = w_neg | w_zero;
            CC_ALWAYS: taken = 1'b1;
            CC_NEZ:    taken = ~w_zero;
            CC_GEZ:    taken = ~w_neg;
            CC_GTZ:    taken = ~w_neg & ~w_zero;
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: program loader plus fetch sequencer with conditional jumps.
// Optional feature macro FETCH_WRAP_HALT_EN: when defined, stepping past the
// last program address halts instead of wrapping pc back to 0.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int PROG_DEPTH = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_start,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    input  logic       load_last,
    output logic       load_ready,
    input  logic       run_start,
    input  logic       halt_req,
    input  logic [7:0] cond_value,
    input  logic [7:0] jump_target,
    output logic [7:0] inst,
    output logic       inst_valid,
    output logic [7:0] pc,
    output logic       halted
);

    localparam int AW = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(PROG_DEPTH - 1);

    fetch_state_e  r_state;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] r_addr;
    logic [7:0]    r_mem [PROG_DEPTH];

    logic [7:0]    w_memRead;
    logic          w_loadAccept;
    logic          w_loadDone;
    logic          w_condRaw;
    logic          w_jumpTaken;
    logic [AW-1:0] w_pcInc;
    logic [AW-1:0] w_jumpPc;

    assign w_memRead    = r_mem[r_pc];
    assign w_loadAccept = (r_state == ST_LOAD) && load_valid;
    assign w_loadDone   = w_loadAccept && (load_last || (r_addr == LAST_ADDR));
    assign w_pcInc      = r_pc + AW'(1);
    assign w_jumpPc     = jump_target[AW-1:0];
    assign w_jumpTaken  = is_cond_inst(w_memRead) && w_condRaw;

    condition_unit u_cond (
        .code  (w_memRead[2:0]),
        .value (cond_value),
        .taken (w_condRaw)
    );

    // Program memory write port; contents survive reset, and a byte presented on a reset edge is dropped
    always_ff @(posedge clk) begin
        if (!rst && w_loadAccept) begin
            r_mem[r_addr] <= load_data;
        end
    end

    // Control FSM: owns state, program counter and load address
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
            r_addr  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (load_start) begin
                        r_state <= ST_LOAD;
                        r_addr  <= '0;
                    end else if (run_start) begin
                        r_state <= ST_RUN;
                        r_pc    <= '0;
                    end
                end
                ST_LOAD: begin
                    if (w_loadAccept) begin
                        r_addr <= r_addr + AW'(1);
                        if (w_loadDone) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_RUN: begin
                    if (halt_req) begin
                        r_state <= ST_HALT;
                    end else if (w_jumpTaken) begin
                        r_pc <= w_jumpPc;
                    end else if (r_pc == LAST_ADDR) begin
`ifdef FETCH_WRAP_HALT_EN
                        r_state <= ST_HALT;
`else
                        r_pc    <= '0;
`endif
                    end else begin
                        r_pc <= w_pcInc;
                    end
                end
                ST_HALT: begin
                    if (load_start) begin
                        r_state <= ST_LOAD;
                        r_addr  <= '0;
                    end else if (run_start) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign load_ready = (r_state == ST_LOAD);
    assign inst_valid = (r_state == ST_RUN);
    assign inst       = inst_valid ? w_memRead : 8'h00;
    assign halted     = (r_state == ST_HALT);

    // Present the narrow program counter zero-extended to the 8-bit port
    always_comb begin
        pc         = 8'h00;
        pc[AW-1:0] = r_pc;
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: a 256-byte instance for the main function
// and a 4-byte instance for address wrap and jump-target truncation.
module tb_instruction_fetch;

    logic       clk = 1'b0;
    logic       rst;

    logic       loadStart, loadValid, loadLast, runStart, haltReq;
    logic [7:0] loadData, condValue, jumpTarget;
    logic       loadReady, instValid, halted;
    logic [7:0] inst, pc;

    logic       sLoadStart, sLoadValid, sLoadLast, sRunStart, sHaltReq;
    logic [7:0] sLoadData, sCondValue, sJumpTarget;
    logic       sLoadReady, sInstValid, sHalted;
    logic [7:0] sInst, sPc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    instruction_fetch #(.PROG_DEPTH(256)) dut (
        .clk(clk), .rst(rst),
        .load_start(loadStart), .load_valid(loadValid), .load_data(loadData),
        .load_last(loadLast), .load_ready(loadReady),
        .run_start(runStart), .halt_req(haltReq),
        .cond_value(condValue), .jump_target(jumpTarget),
        .inst(inst), .inst_valid(instValid), .pc(pc), .halted(halted)
    );

    instruction_fetch #(.PROG_DEPTH(4)) dutSmall (
        .clk(clk), .rst(rst),
        .load_start(sLoadStart), .load_valid(sLoadValid), .load_data(sLoadData),
        .load_last(sLoadLast), .load_ready(sLoadReady),
        .run_start(sRunStart), .halt_req(sHaltReq),
        .cond_value(sCondValue), .jump_target(sJumpTarget),
        .inst(sInst), .inst_valid(sInstValid), .pc(sPc), .halted(sHalted)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic loadByte(input logic [7:0] d, input logic last);
        loadValid = 1'b1;
        loadData  = d;
        loadLast  = last;
        tick();
        loadValid = 1'b0;
        loadLast  = 1'b0;
    endtask

    task automatic resetPulse();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic startRun();
        runStart = 1'b1;
        tick();
        runStart = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++; if (loadReady !== 1'b0) begin bad++; $display("[TB] FAIL reset_load_ready got=%b want=0", loadReady); end
        total++; if (instValid !== 1'b0) begin bad++; $display("[TB] FAIL reset_inst_valid got=%b want=0", instValid); end
        total++; if (inst !== 8'h00) begin bad++; $display("[TB] FAIL reset_inst got=%h want=00", inst); end
        total++; if (halted !== 1'b0) begin bad++; $display("[TB] FAIL reset_halted got=%b want=0", halted); end
        total++; if (pc !== 8'h00) begin bad++; $display("[TB] FAIL reset_pc got=%h want=00", pc); end
        total++; if (sInstValid !== 1'b0 || sLoadReady !== 1'b0) begin bad++; $display("[TB] FAIL reset_small got=%b%b want=00", sInstValid, sLoadReady); end
        rst = 1'b0;
    endtask

    task automatic test_load_run();
        loadStart = 1'b1;
        tick();
        loadStart = 1'b0;
        total++; if (loadReady !== 1'b1) begin bad++; $display("[TB] FAIL load_ready_enter got=%b want=1", loadReady); end
        loadByte(8'h05, 1'b0);
        loadByte(8'h81, 1'b0);
        total++; if (loadReady !== 1'b1) begin bad++; $display("[TB] FAIL load_ready_mid got=%b want=1", loadReady); end
        loadByte(8'hC4, 1'b1);
        total++; if (loadReady !== 1'b0) begin bad++; $display("[TB] FAIL load_ready_last got=%b want=0", loadReady); end
        jumpTarget = 8'h00;
        condValue  = 8'h00;
        startRun();
        total++; if (instValid !== 1'b1 || inst !== 8'h05 || pc !== 8'h00) begin bad++; $display("[TB] FAIL run_first got=%b/%h/%h want=1/05/00", instValid, inst, pc); end
        tick();
        total++; if (inst !== 8'h81 || pc !== 8'h01) begin bad++; $display("[TB] FAIL run_second got=%h/%h want=81/01", inst, pc); end
        tick();
        total++; if (inst !== 8'hC4 || pc !== 8'h02) begin bad++; $display("[TB] FAIL run_third got=%h/%h want=C4/02", inst, pc); end
        tick();
        total++; if (inst !== 8'h05 || pc !== 8'h00) begin bad++; $display("[TB] FAIL run_jump_back got=%h/%h want=05/00", inst, pc); end
        haltReq = 1'b1;
        tick();
        haltReq = 1'b0;
        total++; if (halted !== 1'b1 || pc !== 8'h00 || inst !== 8'h00) begin bad++; $display("[TB] FAIL run_halt got=%b/%h/%h want=1/00/00", halted, pc, inst); end
        resetPulse();
    endtask

    task automatic test_cond_basic();
        loadStart = 1'b1;
        tick();
        loadStart = 1'b0;
        loadByte(8'hC1, 1'b0);
        loadByte(8'hC7, 1'b0);
        loadByte(8'hC2, 1'b0);
        loadByte(8'hC1, 1'b1);
        condValue  = 8'h00;
        jumpTarget = 8'h10;
        startRun();
        tick();
        total++; if (pc !== 8'h10) begin bad++; $display("[TB] FAIL cond_eq_taken pc got=%h want=10", pc); end
        resetPulse();
        condValue = 8'h01;
        startRun();
        tick();
        total++; if (pc !== 8'h01 || inst !== 8'hC7) begin bad++; $display("[TB] FAIL cond_eq_not_taken got=%h/%h want=01/C7", pc, inst); end
        condValue = 8'h80;
        tick();
        total++; if (pc !== 8'h02 || inst !== 8'hC2) begin bad++; $display("[TB] FAIL cond_gt_neg got=%h/%h want=02/C2", pc, inst); end
        jumpTarget = 8'h00;
        tick();
        total++; if (pc !== 8'h00) begin bad++; $display("[TB] FAIL cond_lt_neg pc got=%h want=00", pc); end
        resetPulse();
    endtask

    task automatic test_cond_table();
        logic [2:0]  vCode  [15] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4,
                                     3'd5, 3'd5, 3'd6, 3'd6, 3'd7, 3'd7, 3'd7};
        logic [7:0]  vValue [15] = '{8'h00, 8'h00, 8'h01, 8'h80, 8'h00, 8'h00, 8'h01, 8'h7F,
                                     8'h00, 8'hFF, 8'h00, 8'hFF, 8'h80, 8'h01, 8'h00};
        logic        vTaken [15] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                                     1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [7:0]  expPc;
        for (int i = 0; i < 15; i++) begin
            loadStart = 1'b1;
            tick();
            loadStart = 1'b0;
            loadByte({5'b11000, vCode[i]}, 1'b1);
            condValue  = vValue[i];
            jumpTarget = 8'h40;
            startRun();
            tick();
            expPc = vTaken[i] ? 8'h40 : 8'h01;
            total++; if (pc !== expPc) begin bad++; $display("[TB] FAIL cond_table[%0d] code=%0d value=%h pc got=%h want=%h", i, vCode[i], vValue[i], pc, expPc); end
            resetPulse();
        end
    endtask

    task automatic test_halt_priority();
        loadStart = 1'b1;
        tick();
        loadStart = 1'b0;
        loadByte(8'h00, 1'b0);
        loadByte(8'h00, 1'b0);
        loadByte(8'h00, 1'b0);
        loadByte(8'hC4, 1'b1);
        jumpTarget = 8'h00;
        startRun();
        tick();
        tick();
        tick();
        total++; if (pc !== 8'h03 || inst !== 8'hC4) begin bad++; $display("[TB] FAIL halt_setup got=%h/%h want=03/C4", pc, inst); end
        haltReq = 1'b1;
        tick();
        haltReq = 1'b0;
        total++; if (halted !== 1'b1 || pc !== 8'h03 || instValid !== 1'b0 || inst !== 8'h00) begin bad++; $display("[TB] FAIL halt_over_jump got=%b/%h/%b/%h want=1/03/0/00", halted, pc, instValid, inst); end
        startRun();
        total++; if (halted !== 1'b0 || instValid !== 1'b1 || inst !== 8'hC4 || pc !== 8'h03) begin bad++; $display("[TB] FAIL halt_resume got=%b/%b/%h/%h want=0/1/C4/03", halted, instValid, inst, pc); end
        haltReq = 1'b1;
        tick();
        haltReq   = 1'b0;
        loadStart = 1'b1;
        runStart  = 1'b1;
        tick();
        loadStart = 1'b0;
        runStart  = 1'b0;
        total++; if (loadReady !== 1'b1 || instValid !== 1'b0) begin bad++; $display("[TB] FAIL halt_load_wins got=%b/%b want=1/0", loadReady, instValid); end
        resetPulse();
    endtask

    task automatic test_reset_during_load();
        loadStart = 1'b1;
        tick();
        loadStart = 1'b0;
        loadByte(8'hAA, 1'b0);
        loadByte(8'hBB, 1'b0);
        rst       = 1'b1;
        loadValid = 1'b1;
        loadData  = 8'hCC;
        tick();
        rst       = 1'b0;
        loadValid = 1'b0;
        total++; if (loadReady !== 1'b0 || halted !== 1'b0 || instValid !== 1'b0) begin bad++; $display("[TB] FAIL rst_load_idle got=%b/%b/%b want=0/0/0", loadReady, halted, instValid); end
        startRun();
        total++; if (inst !== 8'hAA) begin bad++; $display("[TB] FAIL rst_load_keep0 got=%h want=AA", inst); end
        tick();
        total++; if (inst !== 8'hBB) begin bad++; $display("[TB] FAIL rst_load_keep1 got=%h want=BB", inst); end
        tick();
        total++; if (inst !== 8'h00) begin bad++; $display("[TB] FAIL rst_load_nowrite got=%h want=00", inst); end
        resetPulse();
        loadStart = 1'b1;
        tick();
        loadStart = 1'b0;
        loadByte(8'h11, 1'b1);
        startRun();
        total++; if (inst !== 8'h11) begin bad++; $display("[TB] FAIL rst_load_addr0 got=%h want=11", inst); end
        tick();
        total++; if (inst !== 8'hBB) begin bad++; $display("[TB] FAIL rst_load_addr1 got=%h want=BB", inst); end
        resetPulse();
    endtask

    task automatic test_wrap();
        logic [7:0] prog [4] = '{8'h01, 8'hC4, 8'h03, 8'h04};
        sLoadStart = 1'b1;
        tick();
        sLoadStart = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sLoadValid = 1'b1;
            sLoadData  = prog[i];
            tick();
        end
        sLoadValid = 1'b0;
        total++; if (sLoadReady !== 1'b0) begin bad++; $display("[TB] FAIL wrap_load_full got=%b want=0", sLoadReady); end
        sJumpTarget = 8'hF2;
        sRunStart   = 1'b1;
        tick();
        sRunStart = 1'b0;
        total++; if (sPc !== 8'h00 || sInst !== 8'h01) begin bad++; $display("[TB] FAIL wrap_start got=%h/%h want=00/01", sPc, sInst); end
        tick();
        tick();
        total++; if (sPc !== 8'h02 || sInst !== 8'h03) begin bad++; $display("[TB] FAIL wrap_jump_trunc got=%h/%h want=02/03", sPc, sInst); end
        tick();
        total++; if (sPc !== 8'h03 || sInst !== 8'h04) begin bad++; $display("[TB] FAIL wrap_last got=%h/%h want=03/04", sPc, sInst); end
        tick();
`ifdef FETCH_WRAP_HALT_EN
        total++; if (sHalted !== 1'b1 || sPc !== 8'h03 || sInstValid !== 1'b0) begin bad++; $display("[TB] FAIL wrap_step got=%b/%h/%b want=1/03/0", sHalted, sPc, sInstValid); end
`else
        total++; if (sHalted !== 1'b0 || sPc !== 8'h00 || sInstValid !== 1'b1 || sInst !== 8'h01) begin bad++; $display("[TB] FAIL wrap_step got=%b/%h/%b/%h want=0/00/1/01", sHalted, sPc, sInstValid, sInst); end
`endif
        resetPulse();
    endtask

    initial begin
        rst = 1'b1;
        loadStart = 1'b0; loadValid = 1'b0; loadLast = 1'b0; runStart = 1'b0; haltReq = 1'b0;
        loadData = 8'h00; condValue = 8'h00; jumpTarget = 8'h00;
        sLoadStart = 1'b0; sLoadValid = 1'b0; sLoadLast = 1'b0; sRunStart = 1'b0; sHaltReq = 1'b0;
        sLoadData = 8'h00; sCondValue = 8'h00; sJumpTarget = 8'h00;

        test_reset();
        test_load_run();
        test_cond_basic();
        test_cond_table();
        test_halt_priority();
        test_reset_during_load();
        test_wrap();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
